// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned WAIT_W      = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, stage-register controls and status between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = pipeline_ctrl_pkg::CNT_W_DEF
);
  import pipeline_ctrl_pkg::*;

  reg_idx_t         if_id_rs;
  reg_idx_t         if_id_rt;
  reg_idx_t         id_ex_rt;
  logic             id_ex_memRead;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ack;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_id_rs, if_id_rt, id_ex_rt, id_ex_memRead, branch_taken, dmem_req, dmem_ack,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_bubble, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_ex_rt, id_ex_memRead, branch_taken, dmem_req, dmem_ack,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush,
           mem_wb_bubble, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use hazards, taken branches, data-memory waits
// with timeout, plus stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic load_use;
  logic mem_stall;
  logic ack_valid;
  logic advance;

  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic ex_mem_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic mem_wb_bubble;
  logic mem_err;

  assign load_use  = bus.id_ex_memRead && (bus.id_ex_rt != '0) &&
                     ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
  assign mem_stall = bus.dmem_req && !bus.dmem_ack;
  // An ack only counts while a request is actually outstanding.
  assign ack_valid = bus.dmem_req && bus.dmem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          wait_d  = WAIT_W'(1);
          // The first frozen cycle already counts toward the timeout.
          state_d = (TIMEOUT <= 1) ? ST_ERR : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (ack_valid) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d >= TIMEOUT_W) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    ex_mem_write  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b1;
    mem_err       = 1'b0;
    advance       = 1'b0;
    if (rst_n) begin
      mem_err = (state_q == ST_ERR);
      advance = ((state_q == ST_RUN) && !mem_stall) ||
                ((state_q == ST_MEM_WAIT) && ack_valid);
      if (advance) begin
        mem_wb_bubble = 1'b0;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if (bus.branch_taken) begin
          // Younger instructions are on the wrong path, so any load-use hazard is moot.
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          id_ex_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n && !pc_write),
    .cnt   (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (if_id_flush),
    .cnt   (bus.flush_cnt)
  );

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.id_ex_write   = id_ex_write;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_err       = mem_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (TIMEOUT=4/CNT_W=4 and defaults) share stimulus
// and are checked against a cycle-level behavioural model plus fixed vectors.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] in_rs, in_rt, in_exrt;
  logic       in_mr, in_br, in_req, in_ack;

  int n_cmp;
  int n_fail;

  // Model state per instance: 0 = TIMEOUT 4 / CNT_W 4, 1 = defaults.
  int m_to[2]  = '{4, 15};
  int m_max[2] = '{15, 65535};
  int m_wait[2];
  bit m_err[2];
  int m_stall[2];
  int m_flush[2];

  pipeline_ctrl_if #(.CNT_W(4))  bus_a ();
  pipeline_ctrl_if #(.CNT_W(16)) bus_b ();

  assign bus_a.if_id_rs = in_rs;   assign bus_b.if_id_rs = in_rs;
  assign bus_a.if_id_rt = in_rt;   assign bus_b.if_id_rt = in_rt;
  assign bus_a.id_ex_rt = in_exrt; assign bus_b.id_ex_rt = in_exrt;
  assign bus_a.id_ex_memRead = in_mr; assign bus_b.id_ex_memRead = in_mr;
  assign bus_a.branch_taken  = in_br; assign bus_b.branch_taken  = in_br;
  assign bus_a.dmem_req = in_req;  assign bus_b.dmem_req = in_req;
  assign bus_a.dmem_ack = in_ack;  assign bus_b.dmem_ack = in_ack;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  pipeline_ctrl #(.TIMEOUT(15), .CNT_W(16)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: {pc, if_id_w, id_ex_w, ex_mem_w, if_id_flush, id_ex_flush, bubble, mem_err}
  function automatic logic [7:0] got_a();
    return {bus_a.pc_write, bus_a.if_id_write, bus_a.id_ex_write, bus_a.ex_mem_write,
            bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.mem_wb_bubble, bus_a.mem_err};
  endfunction

  function automatic logic [7:0] got_b();
    return {bus_b.pc_write, bus_b.if_id_write, bus_b.id_ex_write, bus_b.ex_mem_write,
            bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.mem_wb_bubble, bus_b.mem_err};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exrt,
                        input logic mr, input logic br, input logic req, input logic ack);
    in_rs = rs; in_rt = rt; in_exrt = exrt;
    in_mr = mr; in_br = br; in_req = req; in_ack = ack;
  endtask

  // Called just after a rising edge with inputs already applied; checks at the falling
  // edge, then advances the model across the next rising edge.
  task automatic step(input bit use_tbl, input logic [7:0] tbl_exp, input string tag);
    logic [7:0] e[2];
    bit         waitcyc[2];
    bit         hazard, acked;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_wait[i] = 0; m_err[i] = 1'b0; m_stall[i] = 0; m_flush[i] = 0;
      end
    end
    hazard = in_mr && (in_exrt != 5'd0) && ((in_exrt == in_rs) || (in_exrt == in_rt));
    acked  = in_req && in_ack;
    for (int i = 0; i < 2; i++) begin
      waitcyc[i] = 1'b0;
      if (!rst_n)                                          e[i] = 8'h02;
      else if (m_err[i])                                   e[i] = 8'h03;
      else if ((m_wait[i] > 0) ? !acked : (in_req && !in_ack)) begin
        e[i] = 8'h02; waitcyc[i] = 1'b1;
      end
      else if (in_br)                                      e[i] = 8'hFC;
      else if (hazard)                                     e[i] = 8'h34;
      else                                                 e[i] = 8'hF0;
    end
    @(negedge clk);
    chk({tag, "/a_out"},   int'(got_a()), int'(e[0]));
    chk({tag, "/b_out"},   int'(got_b()), int'(e[1]));
    chk({tag, "/a_stall"}, int'(bus_a.stall_cnt), m_stall[0]);
    chk({tag, "/b_stall"}, int'(bus_b.stall_cnt), m_stall[1]);
    chk({tag, "/a_flush"}, int'(bus_a.flush_cnt), m_flush[0]);
    chk({tag, "/b_flush"}, int'(bus_b.flush_cnt), m_flush[1]);
    if (use_tbl) chk({tag, "/a_vec"}, int'(got_a()), int'(tbl_exp));
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (!e[i][7] && m_stall[i] < m_max[i]) m_stall[i]++;
        if (e[i][3] && m_flush[i] < m_max[i])  m_flush[i]++;
        if (waitcyc[i]) begin
          m_wait[i]++;
          if (m_wait[i] >= m_to[i]) m_err[i] = 1'b1;
        end else begin
          m_wait[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, "reset");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, exrt;
    logic       mr, br, req, ack;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tbl[0] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, "normal"};
    tbl[1] = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34, "lu_rs"};
    tbl[2] = '{5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h34, "lu_rt"};
    tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, "lu_r0"};
    tbl[4] = '{5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, "no_load"};
    tbl[5] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, "branch"};
    tbl[6] = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFC, "br_lu"};
    tbl[7] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, "req_ack"};
    tbl[8] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, "stray_ack"};
    tbl[9] = '{5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, "ack_lu"};

    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    for (int k = 0; k < 10; k++) begin
      set_in(tbl[k].rs, tbl[k].rt, tbl[k].exrt, tbl[k].mr, tbl[k].br, tbl[k].req, tbl[k].ack);
      step(1'b1, tbl[k].exp, tbl[k].name);
    end

    // Single load-use, then a zero-register load that must not stall.
    do_reset();
    set_in(5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h34, "lu_once");
    chk("lu_once_stall_cnt", int'(bus_a.stall_cnt), 1);
    set_in(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, "lu_r0_after");
    chk("lu_r0_stall_cnt", int'(bus_a.stall_cnt), 1);

    // Branch and load-use in the same cycle.
    do_reset();
    set_in(5'd8, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hFC, "br_lu_seq");
    chk("br_lu_flush_cnt", int'(bus_a.flush_cnt), 1);
    chk("br_lu_stall_cnt", int'(bus_a.stall_cnt), 0);

    // Memory wait: three frozen cycles, release on the ack cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, "mwait_freeze");
    end
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hF0, "mwait_ack");
    chk("mwait_stall_cnt", int'(bus_a.stall_cnt), 3);
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hF0, "mwait_back_run");

    // Timeout on instance a: four wait cycles then sticky error; later ack ignored.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, "tmo_wait");
    end
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h03, "tmo_err");
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h03, "tmo_ack_ignored");
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h03, "tmo_sticky");

    // Reset in the middle of a wait clears everything at once.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h02, "rmid_wait");
    end
    rst_n = 1'b0;
    #1;
    chk("rmid_stall_cnt_now", int'(bus_a.stall_cnt), 0);
    chk("rmid_bubble_now", int'(got_a()), 8'h02);
    step(1'b1, 8'h02, "rmid_in_reset");
    rst_n = 1'b1;
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hF0, "rmid_run");

    // Saturation of the narrow counter.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h34, "sat_lu");
    end
    chk("sat_a_stall_cnt", int'(bus_a.stall_cnt), 15);
    chk("sat_b_stall_cnt", int'(bus_b.stall_cnt), 20);

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
      step(1'b0, 8'h00, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
